// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register:
//   - 3-bit operation codes used by single-cycle ops and the shift FSM
//   - FSM state encodings
// No ports; imported by usr_next_value and universal_shift_register.
// -----------------------------------------------------------------------------
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_CLR  = 3'd2;
    localparam logic [2:0] MODE_SHL  = 3'd3;
    localparam logic [2:0] MODE_SHR  = 3'd4;
    localparam logic [2:0] MODE_ROL  = 3'd5;
    localparam logic [2:0] MODE_ROR  = 3'd6;
    localparam logic [2:0] MODE_ASR  = 3'd7;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

endpackage : usr_pkg

// File: rtl/usr_next_value.sv
// -----------------------------------------------------------------------------
// usr_next_value
// Purely combinational next-value function of the shift register. Both the
// single-cycle path and the multi-cycle FSM steps go through this block so the
// operation set is defined in exactly one place.
// Ports:
//   q_i       current register contents
//   mode_i    operation code (MODE_* in usr_pkg)
//   sin_i     serial fill bit for SHL / SHR
//   par_in_i  parallel load data
//   q_next_o  resulting register value
// -----------------------------------------------------------------------------
module usr_next_value
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       mode_i,
    input  logic             sin_i,
    input  logic [WIDTH-1:0] par_in_i,
    output logic [WIDTH-1:0] q_next_o
);

    // Operation decode: one result per op code, hold for anything unexpected.
    always_comb begin
        q_next_o = q_i;
        case (mode_i)
            MODE_HOLD: q_next_o = q_i;
            MODE_LOAD: q_next_o = par_in_i;
            MODE_CLR:  q_next_o = '0;
            MODE_SHL:  q_next_o = {q_i[WIDTH-2:0], sin_i};
            MODE_SHR:  q_next_o = {sin_i, q_i[WIDTH-1:1]};
            MODE_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            MODE_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
            MODE_ASR:  q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            default:   q_next_o = q_i;
        endcase
    end

endmodule : usr_next_value

// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
// WIDTH-bit register with per-cycle ops (hold/load/clear/shift/rotate/asr) and
// a multi-cycle "shift by N" command sequenced by a two-state FSM.
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   en_i         clock enable; 0 freezes q, count and FSM, and suppresses done
//   mode_i       op code (MODE_* in usr_pkg)
//   start_i      launch a multi-cycle command of amt_i steps using mode_i
//   amt_i        step count, saturated to WIDTH
//   par_in_i     parallel load data
//   sin_i        serial fill bit, sampled live on every step
//   q_o          register contents
//   sout_msb_o   q_o[WIDTH-1]
//   sout_lsb_o   q_o[0]
//   busy_o       registered, high while the FSM is in SHIFT
//   done_o       registered one-cycle pulse after a command returns to IDLE
// -----------------------------------------------------------------------------
module universal_shift_register
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic             start_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic [WIDTH-1:0] par_in_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sout_msb_o,
    output logic             sout_lsb_o,
    output logic             busy_o,
    output logic             done_o
);

    logic             state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2:0]       op_sel_s;
    logic [WIDTH-1:0] q_next_s;
    logic [AMT_W-1:0] amt_sat_s;

    // Requests beyond WIDTH steps are clipped to WIDTH.
    assign amt_sat_s = (amt_i > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt_i;

    // While shifting, the latched op drives the shared next-value logic;
    // otherwise the live mode input does.
    assign op_sel_s = (state_q == ST_SHIFT) ? op_q : mode_i;

    usr_next_value #(
        .WIDTH    (WIDTH)
    ) u_next_value (
        .q_i      (q_q),
        .mode_i   (op_sel_s),
        .sin_i    (sin_i),
        .par_in_i (par_in_i),
        .q_next_o (q_next_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (en_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM outputs (registered below): busy follows the next state; done marks
    // the enabled SHIFT->IDLE transition only, so it is never stretched.
    always_comb begin
        busy_d = (state_d == ST_SHIFT);
        if (en_i && (state_q == ST_SHIFT) && (state_d == ST_IDLE)) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // Datapath next-state: register value, remaining steps and latched op.
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        op_d  = op_q;
        if (en_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        // Acceptance edge leaves q untouched.
                        op_d  = mode_i;
                        cnt_d = amt_sat_s;
                    end else begin
                        q_d = q_next_s;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q != '0) begin
                        q_d   = q_next_s;
                        cnt_d = cnt_q - AMT_W'(1);
                    end else begin
                        q_d   = q_q;
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    q_d   = q_q;
                    cnt_d = cnt_q;
                    op_d  = op_q;
                end
            endcase
        end else begin
            q_d   = q_q;
            cnt_d = cnt_q;
            op_d  = op_q;
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q    <= '0;
            cnt_q  <= '0;
            op_q   <= MODE_HOLD;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign q_o        = q_q;
    assign sout_msb_o = q_q[WIDTH-1];
    assign sout_lsb_o = q_q[0];
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule : universal_shift_register

// File: tb/tb_universal_shift_register.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_register
// Directed, self-checking bench for universal_shift_register at WIDTH=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_universal_shift_register;

    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] mode;
    logic       start;
    logic [3:0] amt;
    logic [7:0] par_in;
    logic       sin;
    logic [7:0] q;
    logic       sout_msb;
    logic       sout_lsb;
    logic       busy;
    logic       done;

    int passed = 0;
    int total  = 0;

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, CLR = 3'd2, SHL = 3'd3,
                           SHR = 3'd4, ROL = 3'd5, ROR = 3'd6, ASR = 3'd7;

    universal_shift_register #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .mode_i     (mode),
        .start_i    (start),
        .amt_i      (amt),
        .par_in_i   (par_in),
        .sin_i      (sin),
        .q_o        (q),
        .sout_msb_o (sout_msb),
        .sout_lsb_o (sout_lsb),
        .busy_o     (busy),
        .done_o     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle to the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; mode = LOAD; par_in = 8'hFF;
        start = 1'b0; amt = 4'd0; sin = 1'b0;
        step(); step();
        total++;
        if ({q, busy, done} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL reset_hold: q/busy/done=%h/%b/%b want 00/0/0", q, busy, done);
        else passed++;
        rst_n = 1'b1;
        mode = LOAD; par_in = 8'hA5;
        step();
        total++;
        if (q !== 8'hA5) $display("FAIL reset_release_load: q=%h want a5", q);
        else passed++;
        mode = HOLD;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (q !== 8'h00) $display("FAIL reset_async: q=%h want 00", q);
        else passed++;
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_ops();
        logic [2:0] modes [6] = '{LOAD, SHL, ROR, ASR, SHR, CLR};
        logic       sins  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] exps  [6] = '{8'hA5, 8'h4B, 8'hA5, 8'hD2, 8'h69, 8'h00};
        par_in = 8'hA5; start = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mode = modes[i]; sin = sins[i];
            step();
            total++;
            if ({q, busy, done} !== {exps[i], 1'b0, 1'b0})
                $display("FAIL single_op_%0d: q/busy/done=%h/%b/%b want %h/0/0",
                         i, q, busy, done, exps[i]);
            else passed++;
            if (i == 4) begin
                total++;
                if ({sout_msb, sout_lsb} !== 2'b01)
                    $display("FAIL serial_outs: msb/lsb=%b%b want 01", sout_msb, sout_lsb);
                else passed++;
            end
        end
        mode = HOLD;
    endtask

    task automatic test_multi_shift();
        logic [7:0] exps [4] = '{8'h81, 8'h03, 8'h06, 8'h0C};
        mode = LOAD; par_in = 8'h81;
        step();
        mode = ROL; start = 1'b1; amt = 4'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            // Disturb every command input while busy.
            mode = CLR; start = 1'b1; amt = 4'd1; par_in = 8'h00; sin = 1'b1;
            total++;
            if ({q, busy, done} !== {exps[i], 1'b1, 1'b0})
                $display("FAIL multi_edge_%0d: q/busy/done=%h/%b/%b want %h/1/0",
                         i, q, busy, done, exps[i]);
            else passed++;
        end
        start = 1'b0; mode = HOLD;
        step();
        total++;
        if ({q, busy, done} !== {8'h0C, 1'b0, 1'b1})
            $display("FAIL multi_done: q/busy/done=%h/%b/%b want 0c/0/1", q, busy, done);
        else passed++;
        step();
        total++;
        if ({q, busy, done} !== {8'h0C, 1'b0, 1'b0})
            $display("FAIL multi_done_pulse: q/busy/done=%h/%b/%b want 0c/0/0", q, busy, done);
        else passed++;
    endtask

    task automatic test_boundaries();
        // amt = 0
        mode = SHL; sin = 1'b1; start = 1'b1; amt = 4'd0;
        step();
        start = 1'b0; mode = HOLD;
        total++;
        if ({q, busy, done} !== {8'h0C, 1'b1, 1'b0})
            $display("FAIL amt0_accept: q/busy/done=%h/%b/%b want 0c/1/0", q, busy, done);
        else passed++;
        step();
        total++;
        if ({q, busy, done} !== {8'h0C, 1'b0, 1'b1})
            $display("FAIL amt0_done: q/busy/done=%h/%b/%b want 0c/0/1", q, busy, done);
        else passed++;
        // amt = 9 saturates to 8 rotates
        mode = ROL; start = 1'b1; amt = 4'd9;
        step();
        start = 1'b0; mode = HOLD;
        step();
        total++;
        if (q !== 8'h18) $display("FAIL amt9_first_step: q=%h want 18", q);
        else passed++;
        for (int i = 0; i < 7; i++) step();
        total++;
        if ({q, busy, done} !== {8'h0C, 1'b1, 1'b0})
            $display("FAIL amt9_after_8: q/busy/done=%h/%b/%b want 0c/1/0", q, busy, done);
        else passed++;
        step();
        total++;
        if ({q, busy, done} !== {8'h0C, 1'b0, 1'b1})
            $display("FAIL amt9_saturate: q/busy/done=%h/%b/%b want 0c/0/1", q, busy, done);
        else passed++;
    endtask

    task automatic test_stall_abort();
        logic [7:0] exps [3] = '{8'h07, 8'h0F, 8'h1F};
        mode = LOAD; par_in = 8'h01;
        step();
        mode = SHL; sin = 1'b1; start = 1'b1; amt = 4'd4;
        step();
        start = 1'b0; mode = HOLD;
        step();
        total++;
        if (q !== 8'h03) $display("FAIL stall_pre: q=%h want 03", q);
        else passed++;
        en = 1'b0;
        step(); step();
        total++;
        if ({q, busy, done} !== {8'h03, 1'b1, 1'b0})
            $display("FAIL stall_frozen: q/busy/done=%h/%b/%b want 03/1/0", q, busy, done);
        else passed++;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({q, busy} !== {exps[i], 1'b1})
                $display("FAIL stall_resume_%0d: q/busy=%h/%b want %h/1", i, q, busy, exps[i]);
            else passed++;
        end
        // Stall on the completion edge: no done, still busy.
        en = 1'b0;
        step();
        total++;
        if ({q, busy, done} !== {8'h1F, 1'b1, 1'b0})
            $display("FAIL stall_on_done: q/busy/done=%h/%b/%b want 1f/1/0", q, busy, done);
        else passed++;
        en = 1'b1;
        step();
        total++;
        if ({q, busy, done} !== {8'h1F, 1'b0, 1'b1})
            $display("FAIL stall_total_ops: q/busy/done=%h/%b/%b want 1f/0/1", q, busy, done);
        else passed++;
        // Abort mid-command with reset.
        mode = SHL; sin = 1'b0; start = 1'b1; amt = 4'd4;
        step();
        start = 1'b0; mode = HOLD;
        step();
        total++;
        if (q !== 8'h3E) $display("FAIL abort_pre: q=%h want 3e", q);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({q, busy, done} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL abort_async: q/busy/done=%h/%b/%b want 00/0/0", q, busy, done);
        else passed++;
        step();
        rst_n = 1'b1;
        step(); step(); step();
        total++;
        if ({q, busy, done} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL abort_no_done: q/busy/done=%h/%b/%b want 00/0/0", q, busy, done);
        else passed++;
    endtask

    task automatic test_back_to_back();
        mode = LOAD; par_in = 8'h1F;
        step();
        mode = ROR; start = 1'b1; amt = 4'd1;
        step();
        start = 1'b0; mode = HOLD;
        step();
        total++;
        if (q !== 8'h8F) $display("FAIL b2b_first: q=%h want 8f", q);
        else passed++;
        step();
        total++;
        if ({busy, done} !== 2'b01)
            $display("FAIL b2b_done: busy/done=%b/%b want 0/1", busy, done);
        else passed++;
        mode = SHL; sin = 1'b0; start = 1'b1; amt = 4'd2;
        step();
        start = 1'b0; mode = HOLD;
        total++;
        if ({q, busy, done} !== {8'h8F, 1'b1, 1'b0})
            $display("FAIL b2b_accept: q/busy/done=%h/%b/%b want 8f/1/0", q, busy, done);
        else passed++;
        step(); step();
        total++;
        if (q !== 8'h3C) $display("FAIL b2b_shift: q=%h want 3c", q);
        else passed++;
        step();
        total++;
        if ({q, busy, done} !== {8'h3C, 1'b0, 1'b1})
            $display("FAIL b2b_second_done: q/busy/done=%h/%b/%b want 3c/0/1", q, busy, done);
        else passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_ops();
        test_multi_shift();
        test_boundaries();
        test_stall_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_universal_shift_register
